idt_cfg_serializer: RTL and testbench



---
 rtl/pano_pkg.sv | 47 ++++
 rtl/idt_cfg_serializer.sv | 159 +++++++++++++++
 tb/tb_idt_cfg_serializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pano_pkg.sv
// Shared definitions for the IDT clock synthesizer programming path:
// the serial word layout, a packing helper and the serializer FSM states.
package pano_pkg;

    localparam int IDT_CFG_BITS = 24;

    localparam int IDT_R_LSB   = 0;
    localparam int IDT_R_W     = 7;
    localparam int IDT_V_LSB   = 7;
    localparam int IDT_V_W     = 9;
    localparam int IDT_S_LSB   = 16;
    localparam int IDT_S_W     = 3;
    localparam int IDT_F_LSB   = 19;
    localparam int IDT_F_W     = 2;
    localparam int IDT_TTL_LSB = 21;
    localparam int IDT_C_LSB   = 22;
    localparam int IDT_C_W     = 2;

    typedef enum logic [2:0] {
        IDT_IDLE   = 3'd0,
        IDT_CLK_LO = 3'd1,
        IDT_CLK_HI = 3'd2,
        IDT_STROBE = 3'd3,
        IDT_GAP    = 3'd4
    } idt_state_e;

    // CLK1 = iclk * 2 * (V+8) / (R+2) / S
    function automatic logic [IDT_CFG_BITS-1:0] idt_pack(
        input logic [IDT_C_W-1:0] c,
        input logic               ttl,
        input logic [IDT_F_W-1:0] f,
        input logic [IDT_S_W-1:0] s,
        input logic [IDT_V_W-1:0] v,
        input logic [IDT_R_W-1:0] r
    );
        logic [IDT_CFG_BITS-1:0] w;
        w = '0;
        w[IDT_C_LSB +: IDT_C_W] = c;
        w[IDT_TTL_LSB]          = ttl;
        w[IDT_F_LSB +: IDT_F_W] = f;
        w[IDT_S_LSB +: IDT_S_W] = s;
        w[IDT_V_LSB +: IDT_V_W] = v;
        w[IDT_R_LSB +: IDT_R_W] = r;
        return w;
    endfunction

endpackage

// File: rtl/idt_cfg_serializer.sv
// Shifts one 24-bit IDT configuration word out MSB first on sclk/data, then
// pulses the load strobe. Every output comes straight from a flop.
module idt_cfg_serializer
    import pano_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int STROBE_LEN = 2
) (
    input  logic                    osc_clk,
    input  logic                    osc_reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [IDT_CFG_BITS-1:0] cfg_word,
    output logic                    busy,
    output logic                    done,
    output logic                    idt_sclk,
    output logic                    idt_data,
    output logic                    idt_strobe,
    output logic [2:0]              dbg_state_o
);

    localparam int PW  = $clog2(CLK_DIV + 1);
    localparam int SW  = $clog2(STROBE_LEN + 1);
    localparam int BW  = $clog2(IDT_CFG_BITS);
    localparam int MSB = IDT_CFG_BITS - 1;

    localparam logic [PW-1:0] PH_LOAD  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] ST_LOAD  = SW'(STROBE_LEN - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(IDT_CFG_BITS - 1);

    idt_state_e              state_q,  state_d;
    logic [PW-1:0]           phase_q,  phase_d;
    logic [SW-1:0]           strb_q,   strb_d;
    logic [BW-1:0]           bit_q,    bit_d;
    logic [IDT_CFG_BITS-1:0] shift_q,  shift_d;
    logic                    sclk_q,   sclk_d;
    logic                    data_q,   data_d;
    logic                    strobe_q, strobe_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;
    logic                    ready_q,  ready_d;
    logic                    phase_end;

    assign phase_end = (phase_q == '0);

    // Handshake: a word is taken in any cycle where cfg_valid and cfg_ready are
    // both high; cfg_ready is high only in IDLE, so cfg_valid while busy is ignored.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        strb_d  = strb_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            IDT_IDLE: begin
                if (cfg_valid && ready_q) begin
                    state_d = IDT_CLK_LO;
                    phase_d = PH_LOAD;
                    shift_d = cfg_word;
                    bit_d   = LAST_BIT;
                end
            end
            IDT_CLK_LO: begin
                if (phase_end) begin
                    state_d = IDT_CLK_HI;
                    phase_d = PH_LOAD;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            IDT_CLK_HI: begin
                if (phase_end) begin
                    phase_d = PH_LOAD;
                    shift_d = {shift_q[MSB-1:0], 1'b0};
                    if (bit_q == '0) begin
                        state_d = IDT_STROBE;
                        strb_d  = ST_LOAD;
                    end else begin
                        state_d = IDT_CLK_LO;
                        bit_d   = bit_q - BW'(1);
                    end
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            IDT_STROBE: begin
                if (phase_end) begin
                    phase_d = PH_LOAD;
                    if (strb_q == '0) begin
                        state_d = IDT_GAP;
                    end else begin
                        strb_d = strb_q - SW'(1);
                    end
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            IDT_GAP: begin
                if (phase_end) begin
                    state_d = IDT_IDLE;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            default: begin
                state_d = IDT_IDLE;
            end
        endcase
    end

    // Pin values are decoded from the next state so they change together with it.
    always_comb begin
        sclk_d   = (state_d == IDT_CLK_HI);
        data_d   = ((state_d == IDT_CLK_LO) || (state_d == IDT_CLK_HI)) && shift_d[MSB];
        strobe_d = (state_d == IDT_STROBE);
        busy_d   = (state_d != IDT_IDLE);
        ready_d  = (state_d == IDT_IDLE);
    end

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            state_q  <= IDT_IDLE;
            phase_q  <= '0;
            strb_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sclk_q   <= 1'b0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            strb_q   <= strb_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign idt_sclk    = sclk_q;
    assign idt_data    = data_q;
    assign idt_strobe  = strobe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_idt_cfg_serializer.sv
// Bench for idt_cfg_serializer: instance 0 runs CLK_DIV=4, instance 1 runs CLK_DIV=1.
// A scoreboard queue holds accepted words; a negedge monitor rebuilds each word from the pins.
module tb_idt_cfg_serializer;
    import pano_pkg::*;

    localparam int SLEN = 2;
    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, vld, ready, busy, done, sclk, data, strobe;
    logic [1:0][23:0] word;
    logic [1:0][2:0]  st;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    logic [23:0] exp_q[$];
    int          exp_g_q[$];
    int          exp_t0_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        idt_cfg_serializer #(
            .CLK_DIV    (g == 0 ? DIV0 : DIV1),
            .STROBE_LEN (SLEN)
        ) u_dut (
            .osc_clk     (clk),
            .osc_reset   (rst[g]),
            .cfg_valid   (vld[g]),
            .cfg_ready   (ready[g]),
            .cfg_word    (word[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .idt_sclk    (sclk[g]),
            .idt_data    (data[g]),
            .idt_strobe  (strobe[g]),
            .dbg_state_o (st[g])
        );
    end

    function automatic int div_of(input int g);
        return (g == 0) ? DIV0 : DIV1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [23:0] cap[2];
    int          nbits[2];
    int          rise_c[2];
    int          srise_c[2];
    int          strobe_cnt[2];
    int          done_cnt[2];
    logic [1:0]  p_sclk = '0, p_data = '0, p_strobe = '0, p_done = '0;
    int          m_d, m_t0;
    bit          m_have;

    initial begin
        for (int g = 0; g < 2; g++) begin
            cap[g] = '0; nbits[g] = 0; rise_c[g] = 0; srise_c[g] = 0;
            strobe_cnt[g] = 0; done_cnt[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            m_d    = div_of(g);
            m_have = (exp_q.size() > 0) && (exp_g_q[0] == g);
            m_t0   = m_have ? exp_t0_q[0] : 0;
            if (rst[g]) begin
                cap[g]   = '0;
                nbits[g] = 0;
                if (m_have) begin
                    void'(exp_q.pop_front());
                    void'(exp_g_q.pop_front());
                    void'(exp_t0_q.pop_front());
                end
            end else begin
                if ((busy[g] && ready[g]) || (strobe[g] && sclk[g]) ||
                    (sclk[g] && data[g] !== p_data[g]) || (done[g] && p_done[g])) begin
                    viol++;
                    if (viol < 10)
                        $display("FAIL invariant inst%0d cycle %0d: busy=%b ready=%b sclk=%b data=%b strobe=%b done=%b",
                                 g, cyc, busy[g], ready[g], sclk[g], data[g], strobe[g], done[g]);
                end
                if (sclk[g] && !p_sclk[g]) begin
                    if (!m_have) check("sclk_while_idle", {31'b0, m_have}, 1);
                    else begin
                        check("sclk_rise_cycle", cyc - m_t0, 1 + (2 * nbits[g] + 1) * m_d);
                        cap[g]   = {cap[g][22:0], data[g]};
                        nbits[g] = nbits[g] + 1;
                        rise_c[g] = cyc;
                    end
                end
                if (!sclk[g] && p_sclk[g]) check("sclk_high_len", cyc - rise_c[g], m_d);
                if (strobe[g] && !p_strobe[g]) begin
                    strobe_cnt[g]++;
                    srise_c[g] = cyc;
                    if (!m_have) check("strobe_while_idle", {31'b0, m_have}, 1);
                    else check("strobe_rise_cycle", cyc - m_t0, 1 + 48 * m_d);
                end
                if (!strobe[g] && p_strobe[g]) check("strobe_len", cyc - srise_c[g], SLEN * m_d);
                if (done[g]) begin
                    done_cnt[g]++;
                    if (!m_have) check("done_while_idle", {31'b0, m_have}, 1);
                    else begin
                        check("word_rebuilt", {8'h0, cap[g]}, {8'h0, exp_q[0]});
                        check("bit_count", nbits[g], 24);
                        check("done_cycle", cyc - m_t0, 1 + (49 + SLEN) * m_d);
                        check("ready_with_done", {30'b0, ready[g], busy[g]}, 32'b10);
                        void'(exp_q.pop_front());
                        void'(exp_g_q.pop_front());
                        void'(exp_t0_q.pop_front());
                        cap[g]   = '0;
                        nbits[g] = 0;
                    end
                end
            end
            p_sclk[g]   = sclk[g];
            p_data[g]   = data[g];
            p_strobe[g] = strobe[g];
            p_done[g]   = done[g];
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int g, input logic [23:0] w, input bit hold, output int t0);
        int n;
        n = 0;
        vld[g]  = 1'b1;
        word[g] = w;
        while (ready[g] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", {31'b0, ready[g]}, 1);
        t0 = cyc;
        if (ready[g] === 1'b1) begin
            exp_q.push_back(w);
            exp_g_q.push_back(g);
            exp_t0_q.push_back(t0);
        end
        @(negedge clk);
        if (!hold) vld[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int start, n;
        start = done_cnt[g];
        n = 0;
        while (done_cnt[g] == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_cnt[g] - start, 1);
    endtask

    int t_a, t_b, d0, s0;

    initial begin
        rst  = '1;
        vld  = '0;
        word = '0;

        // reset / idle
        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++)
            check("reset_state", {23'b0, sclk[g], data[g], strobe[g], busy[g], done[g], ready[g], st[g]}, 0);
        rst = '0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("ready_after_reset", {31'b0, ready[g]}, 1);
            check("idle_pins", {27'b0, sclk[g], data[g], strobe[g], busy[g], done[g]}, 0);
        end
        check("idt_pack", {8'h0, idt_pack(2'd0, 1'b1, 2'd1, 3'd3, 9'd8, 7'd4)}, 32'h002B0404);

        // nominal D=4
        s0 = strobe_cnt[0];
        send(0, 24'h2B0404, 1'b0, t_a);
        wait_done(0, 400);
        check("nominal_one_strobe", strobe_cnt[0] - s0, 1);
        repeat (3) @(negedge clk);

        // busy rejection: second word pulsed mid-transfer
        d0 = done_cnt[0];
        send(0, 24'hA5A5A5, 1'b0, t_a);
        repeat (9) @(negedge clk);
        check("reject_pulse_cycle", cyc - t_a, 10);
        check("ready_low_while_busy", {31'b0, ready[0]}, 0);
        vld[0]  = 1'b1;
        word[0] = 24'h123456;
        @(negedge clk);
        vld[0] = 1'b0;
        wait_done(0, 400);
        repeat (250) @(negedge clk);
        check("reject_single_done", done_cnt[0] - d0, 1);
        check("reject_queue_empty", exp_q.size(), 0);

        // reset during bit 12
        send(0, 24'hC35A96, 1'b0, t_a);
        repeat (99) @(negedge clk);
        check("abort_in_bit12", {31'b0, busy[0]}, 1);
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_pins_zero", {23'b0, sclk[0], data[0], strobe[0], busy[0], done[0], ready[0], st[0]}, 0);
        @(negedge clk);
        rst[0] = 1'b0;
        d0 = done_cnt[0];
        s0 = strobe_cnt[0];
        repeat (250) @(negedge clk);
        check("abort_no_done", done_cnt[0] - d0, 0);
        check("abort_no_strobe", strobe_cnt[0] - s0, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        send(0, 24'h5C0A33, 1'b0, t_a);
        wait_done(0, 400);

        // D=1 back-to-back with cfg_valid held
        d0 = done_cnt[1];
        send(1, 24'hFFFFFF, 1'b1, t_a);
        send(1, 24'h000000, 1'b0, t_b);
        check("b2b_accept_in_done", t_b - t_a, 52);
        wait_done(1, 200);
        repeat (20) @(negedge clk);
        check("b2b_two_dones", done_cnt[1] - d0, 2);

        check("invariants", viol, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
